// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute-stage front end for an external combinational ALU. Decoded ops
// arrive on a valid/ready handshake, aluop/funct are translated into the
// 3-bit ALU control code, operands are registered (stage 1) and presented
// to the ALU, and the ALU result is captured into an output register
// (stage 2) that honours downstream backpressure.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   in_aluop, in_funct   00 add, 01 sub, 10 use funct, 11 illegal
//   in_a, in_b           operands
//   alu_a, alu_b, alu_f  stage-1 registers driving the external ALU
//   alu_y, alu_zero      ALU result returned combinationally
//   out_valid/out_ready  downstream handshake
//   out_y, out_zero      registered result and zero flag
//   out_err              op was illegal (result is whatever the ALU gave)
//   done_cnt             completed ops, wraps
//   err_cnt              completed illegal ops, saturates at 255

module alu_exec_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_aluop,
   input  logic [5:0]       in_funct,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_err,
   output logic [CNT_W-1:0] done_cnt,
   output logic [7:0]       err_cnt
);

   localparam logic [2:0] F_AND = 3'b000;
   localparam logic [2:0] F_OR  = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b110;
   localparam logic [2:0] F_SLT = 3'b111;

   localparam logic [CNT_W-1:0] DONE_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic       s1_valid;
   logic       s1_err;
   logic [2:0] dec_f;
   logic       dec_err;
   logic       s2_free;
   logic       load_s1;
   logic       xfer;
   logic       out_fire;

   // Illegal ops still execute as an add so the pipeline never has holes.
   always_comb begin
      dec_f   = F_ADD;
      dec_err = 1'b0;
      case (in_aluop)
         2'b00: dec_f = F_ADD;
         2'b01: dec_f = F_SUB;
         2'b10: begin
            case (in_funct)
               6'b100000: dec_f = F_ADD;
               6'b100010: dec_f = F_SUB;
               6'b100100: dec_f = F_AND;
               6'b100101: dec_f = F_OR;
               6'b101010: dec_f = F_SLT;
               default:   dec_err = 1'b1;
            endcase
         end
         default: dec_err = 1'b1;
      endcase
   end

   // Ready ripples back combinationally from out_ready so a full pipe can
   // advance both stages and accept a new op on the same edge.
   assign s2_free  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_free;
   assign load_s1  = in_valid && in_ready;
   assign xfer     = s1_valid && s2_free;
   assign out_fire = out_valid && out_ready;

   // Stage 1: operand/control registers hold their last value when empty
   // so the ALU inputs stay quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_f    <= 3'b000;
         s1_err   <= 1'b0;
      end else begin
         if (load_s1) begin
            s1_valid <= 1'b1;
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_f    <= dec_f;
            s1_err   <= dec_err;
         end else if (xfer) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: output register, reloaded on transfer, emptied on fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_zero  <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_y     <= alu_y;
            out_zero  <= alu_zero;
            out_err   <= s1_err;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
         err_cnt  <= 8'h00;
      end else if (out_fire) begin
         done_cnt <= done_cnt + DONE_ONE;
         if (out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage front end for the single-cycle/multicycle datapath's combinational ALU (`f[2:0]`, `a`, `b` → `y`, `zero`). It accepts decoded instructions through a valid/ready handshake and translates `aluop`/`funct` into the ALU control code. It registers operands, drives the external ALU, and captures `y`/`zero` into an output register with backpressure. It also keeps completion and illegal-op counters for bench and debug visibility.

## Interface
- `WIDTH`, 32, operand/result width
- `CNT_W`, 16, completed-op counter width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream op valid
- `in_ready`  out  1  stage can accept op
- `in_aluop`  in  2  00 add, 01 sub, 10 use funct, 11 illegal
- `in_funct`  in  6  R-type funct field
- `in_a`, `in_b`  in  WIDTH  operands
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a`, `b` (stage-1 registers)
- `alu_f`  out  3  to ALU `f`
- `alu_y`  in  WIDTH  from ALU `y`
- `alu_zero`  in  1  from ALU `zero`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `out_y`  out  WIDTH  registered result
- `out_zero`  out  1  registered zero flag
- `out_err`  out  1  op was illegal
- `done_cnt`  out  CNT_W  completed ops, wraps
- `err_cnt`  out  8  illegal ops completed, saturates

## Operation
- Decode is combinational on input and registered into stage 1 as `alu_f` and `s1_err`:
  - aluop 00 → 010 (add); aluop 01 → 110 (sub)
  - aluop 10: funct 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111 (slt)
  - aluop 10 with any other funct, or aluop 11: `alu_f`=010 and err=1. The op still flows through. `out_y`/`out_zero` are whatever the ALU returns.
- Stage 1 holds `s1_valid`, `alu_a`, `alu_b`, `alu_f`, `s1_err`.
- Stage 2 is the output register. It holds `out_valid`, `out_y`, `out_zero`, `out_err`, capturing `alu_y`/`alu_zero`/`s1_err`.
- `s2_free` = !out_valid || out_ready; `in_ready` = !s1_valid || s2_free. This is combinational from `out_ready`.
- Stage 1 → stage 2 transfer occurs when `s1_valid && s2_free`. The input loads stage 1 when `in_valid && in_ready`.
- Stage 2 clears when `out_valid && out_ready` and no transfer occurs that cycle.
- When stage 1 is empty, `alu_a`/`alu_b`/`alu_f` hold their last values. They do not toggle.
- Counters update on output fire (`out_valid && out_ready`). `done_cnt` +1 with wrap from 2^CNT_W−1 to 0. `err_cnt` +1 if `out_err`, holding at 255.
- Stage registers change only on accepted transfers. Data is held stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync-released by system) forces all of the following to 0: `s1_valid`, `out_valid`, `out_y`, `out_zero`, `out_err`, `alu_a`, `alu_b`, `alu_f`, `done_cnt`, `err_cnt`. After reset, `in_ready`=1.
- Latency is 2 cycles. For an op accepted at edge N, `alu_*` are valid after N, the result is captured at N+1, and `out_valid`=1 after N+1.
- With `out_ready` held at 1, throughput is 1 op/cycle with no bubbles.
- Backpressure: with `out_ready`=0 and both stages full, `in_ready`=0. When `out_ready` rises, both stages advance on the same edge and `in_ready`=1 in that cycle.
- Simultaneous output fire and stage-1 transfer: stage 2 is reloaded and `out_valid` stays 1.
- Reset mid-operation discards in-flight ops. Counters do not count them.

## Test plan
- Reset mid-stream with 2 ops in flight → all outputs 0, `in_ready`=1, counters 0, no result emitted after release.
- aluop 10 with funct 100000, a=0x00000005, b=0x00000003 → `alu_f`=010. Two cycles later `out_y`=0x00000008, `out_zero`=0, `out_err`=0.
- Back-to-back ops: sub 7−7, slt 1<2, and 0xF0F0F0F0 & 0x0F0F0F0F, with `out_ready`=1. Results are y=0/zero=1, y=1/zero=0, y=0/zero=1 on consecutive cycles. `done_cnt`=3.
- Stall: `out_ready`=0 for 5 cycles while `in_valid`=1 → exactly 2 ops accepted, `in_ready`=0, and `out_y` stable. Releasing `out_ready` delivers ops in order with no loss or duplicate.
- Illegal ops aluop 11 and funct 000000 → `out_err`=1 and `err_cnt`=2. After 260 illegal ops, `err_cnt`=255.
- Preload `done_cnt` to 0xFFFF by streaming 65535 ops, then 1 more op → `done_cnt`=0x0000.
